// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped branch target buffer with 2-bit saturating counters, placed
// upstream of instruction fetch.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   rst              synchronous active-high reset, clears every entry
//   PC_curr          fetch PC to look up (combinational)
//   predict_taken    lookup hit with counter in a taken state
//   predict_target   stored target when predict_taken, else 16'h0000
//   upd_en           a branch was resolved this cycle
//   upd_PC           PC of the resolved branch
//   upd_taken        actual outcome
//   upd_target       actual target
//   upd_pred_taken   prediction that travelled with the branch
//   upd_pred_target  predicted target that travelled with the branch
//   mispredict       combinational flush request
module branch_predictor #(
    parameter int unsigned INDEX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] PC_curr,
    output logic        predict_taken,
    output logic [15:0] predict_target,
    input  logic        upd_en,
    input  logic [15:0] upd_PC,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [15:0] upd_pred_target,
    output logic        mispredict
);

    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int TAG_W   = 15 - INDEX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [15:0]      r_target [ENTRIES];

    logic [INDEX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [INDEX_W-1:0] w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic               w_unused;

    // Bit 0 of the PC is always zero for halfword-aligned instructions.
    assign w_unused = PC_curr[0] ^ upd_PC[0];

    assign w_lk_idx = PC_curr[INDEX_W:1];
    assign w_lk_tag = PC_curr[15:INDEX_W+1];
    assign w_up_idx = upd_PC[INDEX_W:1];
    assign w_up_tag = upd_PC[15:INDEX_W+1];

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_comb begin
        predict_taken  = w_lk_hit & r_ctr[w_lk_idx][1];
        predict_target = predict_taken ? r_target[w_lk_idx] : 16'h0000;
    end

    always_comb begin
        mispredict = upd_en & ((upd_taken != upd_pred_taken) |
                               (upd_taken & upd_pred_taken &
                                (upd_target != upd_pred_target)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'b00;
                r_target[i] <= 16'h0000;
            end
        end else if (upd_en) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    if (r_ctr[w_up_idx] != 2'b11) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                    end
                    r_target[w_up_idx] <= upd_target;
                end else if (r_ctr[w_up_idx] != 2'b00) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever branch aliased to this index.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_ctr[w_up_idx]    <= 2'b10;
                r_target[w_up_idx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan scenarios
// followed by randomized traffic checked against a behavioural table model.
module tb_branch_predictor;

    localparam int NENT = 8;

    logic        clk;
    logic        rst;
    logic [15:0] PC_curr;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        upd_en;
    logic [15:0] upd_PC;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;

    int n_checks;
    int n_errors;

    // Behavioural model: one record per table slot.
    bit m_valid  [NENT];
    int m_tag    [NENT];
    int m_ctr    [NENT];
    int m_target [NENT];

    branch_predictor #(.INDEX_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_curr         (PC_curr),
        .predict_taken   (predict_taken),
        .predict_target  (predict_target),
        .upd_en          (upd_en),
        .upd_PC          (upd_PC),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input int pc);
        return (pc / 2) % NENT;
    endfunction

    function automatic int m_tg(input int pc);
        return pc / (2 * NENT);
    endfunction

    function automatic bit m_hit(input int pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    function automatic bit m_pt(input int pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic int m_ptgt(input int pc);
        return m_pt(pc) ? m_target[m_idx(pc)] : 0;
    endfunction

    function automatic bit m_misp();
        if (!upd_en) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic model_clock();
        int i;
        if (rst) begin
            for (int k = 0; k < NENT; k++) begin
                m_valid[k]  = 1'b0;
                m_tag[k]    = 0;
                m_ctr[k]    = 0;
                m_target[k] = 0;
            end
        end else if (upd_en) begin
            i = m_idx(int'(upd_PC));
            if (m_hit(int'(upd_PC))) begin
                if (upd_taken) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = int'(upd_target);
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = m_tg(int'(upd_PC));
                m_ctr[i]    = 2;
                m_target[i] = int'(upd_target);
            end
        end
    endtask

    // Wait to mid-cycle and compare all outputs against the model.
    task automatic sample(input string tag);
        @(negedge clk);
        check({tag, "_pt"}, 32'(predict_taken), 32'(m_pt(int'(PC_curr))));
        check({tag, "_tgt"}, 32'(predict_target), 32'(m_ptgt(int'(PC_curr))));
        check({tag, "_misp"}, 32'(mispredict), 32'(m_misp()));
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_upd(input logic en, input logic [15:0] pc, input logic tk,
                           input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt);
        upd_en          = en;
        upd_PC          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic idle_lookup(input logic [15:0] pc);
        set_upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        PC_curr = pc;
    endtask

    initial begin
        logic [15:0] pc;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NENT; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = 0; m_ctr[k] = 0; m_target[k] = 0;
        end

        // Reset sanity.
        rst = 1'b1;
        idle_lookup(16'h0010);
        #1;
        sample("rst");
        advance();
        rst = 1'b0;
        sample("post_rst");
        check("post_rst_pt", 32'(predict_taken), 32'd0);
        check("post_rst_tgt", 32'(predict_target), 32'h0000);
        advance();

        // Same-cycle lookup/allocate, also a direction mispredict.
        PC_curr = 16'h0010;
        set_upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        sample("alloc");
        check("alloc_same_pt", 32'(predict_taken), 32'd0);
        check("alloc_misp", 32'(mispredict), 32'd1);
        advance();
        idle_lookup(16'h0010);
        sample("alloc_next");
        check("alloc_next_pt", 32'(predict_taken), 32'd1);
        check("alloc_next_tgt", 32'(predict_target), 32'h0040);
        advance();

        // Two more taken updates saturate at 11; equal targets: no mispredict.
        for (int n = 0; n < 2; n++) begin
            set_upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
            sample("sat");
            check("sat_eq_misp", 32'(mispredict), 32'd0);
            advance();
        end
        set_upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        sample("dec1");
        check("nt_misp", 32'(mispredict), 32'd1);
        advance();
        idle_lookup(16'h0010);
        sample("dec1_lk");
        check("dec1_pt", 32'(predict_taken), 32'd1);
        set_upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        advance();
        idle_lookup(16'h0010);
        sample("dec2_lk");
        check("dec2_pt", 32'(predict_taken), 32'd0);
        check("dec2_tgt", 32'(predict_target), 32'h0000);
        advance();

        // Not-taken miss on an empty slot leaves it invalid.
        set_upd(1'b1, 16'h0024, 1'b0, 16'h0000, 1'b0, 16'h0000);
        PC_curr = 16'h0024;
        sample("ntmiss");
        advance();
        idle_lookup(16'h0024);
        sample("ntmiss_lk");
        check("ntmiss_pt", 32'(predict_taken), 32'd0);
        advance();

        // Aliasing: 0030 evicts 0010 from index 0.
        set_upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        sample("alias_a");
        advance();
        set_upd(1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0, 16'h0000);
        sample("alias_b");
        advance();
        idle_lookup(16'h0010);
        sample("alias_lk10");
        check("alias_10_pt", 32'(predict_taken), 32'd0);
        advance();
        idle_lookup(16'h0030);
        sample("alias_lk30");
        check("alias_30_pt", 32'(predict_taken), 32'd1);
        check("alias_30_tgt", 32'(predict_target), 32'h0100);
        // One not-taken step drops a freshly allocated entry (ctr=10) to weak-not-taken.
        set_upd(1'b1, 16'h0030, 1'b0, 16'h0000, 1'b1, 16'h0100);
        advance();
        idle_lookup(16'h0030);
        sample("alias_dec");
        check("alias_dec_pt", 32'(predict_taken), 32'd0);
        advance();

        // Target mismatch mispredict and target rewrite.
        set_upd(1'b1, 16'h0030, 1'b1, 16'h0080, 1'b1, 16'h0040);
        sample("tmis");
        check("tmis_misp", 32'(mispredict), 32'd1);
        advance();
        idle_lookup(16'h0030);
        sample("tmis_lk");
        check("tmis_tgt", 32'(predict_target), 32'h0080);
        advance();

        // Reset beats a simultaneous update.
        rst = 1'b1;
        set_upd(1'b1, 16'h0036, 1'b1, 16'h0200, 1'b0, 16'h0000);
        advance();
        rst = 1'b0;
        idle_lookup(16'h0036);
        sample("rstupd_lk36");
        check("rstupd_36_pt", 32'(predict_taken), 32'd0);
        advance();
        idle_lookup(16'h0030);
        sample("rstupd_lk30");
        check("rstupd_30_pt", 32'(predict_taken), 32'd0);
        advance();

        // Random traffic over a small PC pool so aliasing and hits are common.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            PC_curr = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) |
                          $urandom_range(0, 1));
            pc = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1));
            if ($urandom_range(0, 1) == 1) begin
                set_upd(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 3) << 6),
                        m_pt(int'(pc)), 16'(m_ptgt(int'(pc))));
            end else begin
                set_upd(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 3) << 6), 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 3) << 6));
            end
            sample("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage pipeline: a direct-mapped branch target buffer with 2-bit saturating counters. It sits directly upstream of the instruction fetch stage. Each cycle it looks up the current PC combinationally and supplies a predicted-taken flag and target to the fetch next-PC mux. The decode stage returns each resolved branch outcome, which trains the table and raises a combinational mispredict flag for the hazard/flush logic.

## Interface
- INDEX_W, default 3: index width. The table holds 2**INDEX_W entries. Legal range 1..6.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PC_curr  input  16  current fetch PC (lookup address).
- predict_taken  output  1  lookup hit whose counter is in a taken state.
- predict_target  output  16  stored target on a predicted-taken lookup, else 16'h0000.
- upd_en  input  1  decode stage has resolved a branch this cycle.
- upd_PC  input  16  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_target  input  16  actual branch target (meaningful when upd_taken=1).
- upd_pred_taken  input  1  predict_taken that travelled with this branch from fetch.
- upd_pred_target  input  16  predict_target that travelled with this branch from fetch.
- mispredict  output  1  resolved outcome or target differs from the prediction; flush request.

## Operation
- Addressing:
  - index = PC[INDEX_W:1]; PC[0] is ignored because instructions are halfword aligned.
  - tag = PC[15:INDEX_W+1].
- Entry contents: valid (1 bit), tag, ctr (2 bits), target (16 bits).
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup (combinational):
  - hit = valid & (stored tag == PC_curr tag).
  - predict_taken = hit & ctr[1].
  - predict_target = predict_taken ? target : 16'h0000.
- Update on the rising edge when upd_en=1:
  - Hit at upd_PC, upd_taken=1: ctr saturating increment (11 stays 11); target <= upd_target.
  - Hit at upd_PC, upd_taken=0: ctr saturating decrement (00 stays 00); target unchanged; valid stays 1.
  - Miss, upd_taken=1: allocate or overwrite the entry (valid=1, tag <= upd_PC tag, ctr=10, target <= upd_target). Any aliasing entry is evicted.
  - Miss, upd_taken=0: no state change.
- upd_en=0: no state change.
- mispredict (combinational) = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- The block has no stall input. The fetch stall only freezes the PC, so lookups simply repeat. The decode stage must assert upd_en only once per resolved branch.

## Timing
- Lookup latency is zero: the prediction is valid in the same cycle as PC_curr.
- An update becomes visible to lookups starting the cycle after the clock edge that writes it.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update contents.
- mispredict has zero latency from the upd_* inputs. It is not registered.
- Reset:
  - On a rising edge with rst=1, every entry becomes valid=0, ctr=00, target=16'h0000.
  - rst takes priority over a simultaneous upd_en.
  - Reset applied mid-training discards all history.
- Outputs after reset, for any PC_curr: predict_taken=0, predict_target=16'h0000. mispredict follows its combinational equation.

## Test plan
- Reset sanity:
  - Stimulus: rst for 1 cycle, then PC_curr=16'h0010.
  - Required response: predict_taken=0, predict_target=0000.
  - Stimulus: upd_en=1, upd_taken=1, upd_pred_taken=0.
  - Required response: mispredict=1 in that same cycle.
- Allocate and saturate:
  - Stimulus: update PC=0010, taken, target=0040.
  - Required response next cycle: lookup 0010 gives predict_taken=1, predict_target=0040 (ctr=10).
  - Stimulus: two more taken updates.
  - Required response: ctr=11. Then one not-taken update leaves predict_taken=1 (ctr=10); a second makes it 0.
- Not-taken miss: update PC=0020, not taken, with an empty entry.
  - Required response: entry stays invalid; a later lookup of 0020 misses.
- Aliasing (INDEX_W=3): train 0010 taken, then update 0030 taken, target=0100. Both PCs map to index 0.
  - Required response: lookup 0010 misses; lookup 0030 gives target 0100 with ctr=10.
- Target mismatch: upd_taken=1, upd_pred_taken=1, upd_target=0080, upd_pred_target=0040.
  - Required response: mispredict=1; the stored target becomes 0080.
  - With equal targets, mispredict=0.
- Same-cycle read/write: PC_curr=upd_PC=0010 on an empty table with a taken update.
  - Required response: predict_taken=0 this cycle and 1 the next.
  - rst asserted together with upd_en: the table stays empty.
